// File: rtl/alarm_ringer_pkg.sv
// Shared types and defaults for the alarm ringer.
// State encoding, default timing constants and the LED rotate helper.
package alarm_ringer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } ring_state_e;

    localparam int RING_SEC_DEF   = 60;
    localparam int SNOOZE_SEC_DEF = 300;
    localparam int SNOOZE_MAX_DEF = 3;

    localparam logic [7:0] LED_INIT = 8'h01;

    function automatic logic [7:0] led_rotl(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

endpackage

// File: rtl/alarm_ringer_edge_rise.sv
// One-bit rising-edge detector with async active-high reset.
// rise is high in the cycle the input is first seen high.
module edge_rise (
    input  logic clk,
    input  logic CR,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or posedge CR) begin
        if (CR) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: rings LEDs and buzzer on an alarm match,
// with stop, bounded snoozes and a bounded ring time.
module alarm_ringer
    import alarm_ringer_pkg::*;
#(
    parameter int RING_SEC   = RING_SEC_DEF,
    parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
    parameter int SNOOZE_MAX = SNOOZE_MAX_DEF,
    parameter int CNT_W      = 9
) (
    input  logic       clk,
    input  logic       CR,
    input  logic       tick_1hz,
    input  logic       active_alarm,
    input  logic       start_light_alarm,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic [7:0] alarm_led,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing
);

    localparam int SC_W = (SNOOZE_MAX < 1) ? 1 : $clog2(SNOOZE_MAX + 1);

    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SEC - 1);
    localparam logic [CNT_W-1:0] SNZ_LAST  = CNT_W'(SNOOZE_SEC - 1);
    localparam logic [SC_W-1:0]  SNZ_MAX   = SC_W'(SNOOZE_MAX);

    logic start_rise;
    logic stop_rise;
    logic snooze_rise;

    edge_rise u_start_edge (
        .clk  (clk),
        .CR   (CR),
        .d    (start_light_alarm),
        .rise (start_rise)
    );

    edge_rise u_stop_edge (
        .clk  (clk),
        .CR   (CR),
        .d    (stop_btn),
        .rise (stop_rise)
    );

    edge_rise u_snooze_edge (
        .clk  (clk),
        .CR   (CR),
        .d    (snooze_btn),
        .rise (snooze_rise)
    );

    ring_state_e     state_q, state_d;
    logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [SC_W-1:0]  snooze_cnt_q, snooze_cnt_d;
    logic [7:0]       led_q, led_d;
    logic             buzzer_q, buzzer_d;
    logic             ringing_q, ringing_d;
    logic             snoozing_q, snoozing_d;

    logic enter_idle;
    logic enter_ring;

    always_comb begin
        state_d      = state_q;
        sec_cnt_d    = sec_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        led_d        = led_q;
        buzzer_d     = buzzer_q;
        enter_idle   = 1'b0;
        enter_ring   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_rise && active_alarm) begin
                    enter_ring   = 1'b1;
                    snooze_cnt_d = '0;
                end
            end
            RING: begin
                if (!active_alarm || stop_rise) begin
                    enter_idle = 1'b1;
                end else if (snooze_rise) begin
                    if (snooze_cnt_q < SNZ_MAX) begin
                        state_d      = SNOOZE;
                        sec_cnt_d    = '0;
                        snooze_cnt_d = snooze_cnt_q + 1'b1;
                        led_d        = '0;
                        buzzer_d     = 1'b0;
                    end else begin
                        enter_idle = 1'b1;
                    end
                end else if (tick_1hz) begin
                    if (sec_cnt_q == RING_LAST) begin
                        enter_idle = 1'b1;
                    end else begin
                        sec_cnt_d = sec_cnt_q + 1'b1;
                        led_d     = led_rotl(led_q);
                        buzzer_d  = ~buzzer_q;
                    end
                end
            end
            SNOOZE: begin
                if (!active_alarm || stop_rise) begin
                    enter_idle = 1'b1;
                end else if (tick_1hz) begin
                    if (sec_cnt_q == SNZ_LAST) begin
                        enter_ring = 1'b1;
                    end else begin
                        sec_cnt_d = sec_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                enter_idle = 1'b1;
            end
        endcase

        // Entry actions shared by several transitions.
        if (enter_idle) begin
            state_d   = IDLE;
            sec_cnt_d = '0;
            led_d     = '0;
            buzzer_d  = 1'b0;
        end
        if (enter_ring) begin
            state_d   = RING;
            sec_cnt_d = '0;
            led_d     = LED_INIT;
            buzzer_d  = 1'b1;
        end

        ringing_d  = (state_d == RING);
        snoozing_d = (state_d == SNOOZE);
    end

    always_ff @(posedge clk or posedge CR) begin
        if (CR) begin
            state_q      <= IDLE;
            sec_cnt_q    <= '0;
            snooze_cnt_q <= '0;
            led_q        <= '0;
            buzzer_q     <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sec_cnt_q    <= sec_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            led_q        <= led_d;
            buzzer_q     <= buzzer_d;
            ringing_q    <= ringing_d;
            snoozing_q   <= snoozing_d;
        end
    end

    assign alarm_led = led_q;
    assign buzzer    = buzzer_q;
    assign ringing   = ringing_q;
    assign snoozing  = snoozing_q;

endmodule
